// File: rtl/spi_stop_deser_if.sv
// Serial-in / word-out signal bundle for spi_stop_deser.
// slave = deserializer side, master = bit source and word consumer side.
interface spi_stop_deser_if #(
  parameter int WIDTH = 10
);
  logic             enable;
  logic             in;
  logic             clear;
  logic             msb_first;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             out_ready;
  logic             finish;
  logic             busy;
  logic             overrun;
  logic             parity_err;

  modport slave (
    input  enable, in, clear, msb_first, out_ready,
    output out, out_valid, finish, busy, overrun, parity_err
  );

  modport master (
    output enable, in, clear, msb_first, out_ready,
    input  out, out_valid, finish, busy, overrun, parity_err
  );
endinterface

// File: rtl/spi_stop_deser.sv
// Continuous serial-to-parallel deserializer with valid/ready output, overrun and busy status.
// Optional even-parity frame bit enabled by defining STOP_DESER_PARITY_EN.
module spi_stop_deser #(
  parameter int WIDTH = 10,
  parameter int CNT_W = 6
) (
  input logic            clk,
  input logic            rst,
  spi_stop_deser_if.slave bus
);

`ifdef STOP_DESER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sreg, sreg_nx, word, out_q;
  logic [CNT_W-1:0] count, cnt_nx, pos;
  logic             done, load, ovr_set;
  logic             finish_q, busy_q, overrun_q;

  // Datapath: place the current bit, advance the counter, detect frame end.
  always_comb begin
    word    = sreg;
    pos     = bus.msb_first ? (CNT_W'(WIDTH - 1) - count) : count;
    sreg_nx = sreg;
    cnt_nx  = count;
    done    = 1'b0;
    if (count < CNT_W'(WIDTH)) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (CNT_W'(i) == pos) word[i] = bus.in;
      end
    end
    if (bus.clear) begin
      sreg_nx = '0;
      cnt_nx  = '0;
    end else if (bus.enable) begin
      if (count == CNT_W'(FRAME - 1)) begin
        // Shift reg restarts from zero so mixed msb_first words hold no stale bits.
        done    = 1'b1;
        cnt_nx  = '0;
        sreg_nx = '0;
      end else begin
        cnt_nx  = count + CNT_W'(1);
        sreg_nx = word;
      end
    end
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    ovr_set  = 1'b0;
    if (done) begin
      if (state == EMPTY || bus.out_ready) begin
        load     = 1'b1;
        state_nx = FULL;
      end else begin
        ovr_set  = 1'b1;
      end
    end else if (state == FULL && bus.out_ready) begin
      state_nx = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg      <= '0;
      count     <= '0;
      out_q     <= '0;
      finish_q  <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sreg     <= sreg_nx;
      count    <= cnt_nx;
      finish_q <= done;
      busy_q   <= (cnt_nx != '0);
      if (load)    out_q     <= word;
      if (ovr_set) overrun_q <= 1'b1;
    end
  end

`ifdef STOP_DESER_PARITY_EN
  logic perr_q;

  // On the parity edge word equals the received data bits.
  always_ff @(posedge clk) begin
    if (rst)       perr_q <= 1'b0;
    else if (done) perr_q <= (^word) ^ bus.in;
  end

  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.out       = out_q;
  assign bus.out_valid = (state == FULL);
  assign bus.finish    = finish_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: doc/spi_stop_deser.md
Name: spi_stop_deser

Overview:
Parametrised serial-to-parallel deserializer: the next generation of the SPI receive path. Shifts one bit per enabled clock into a WIDTH-bit word, MSB- or LSB-first, and presents completed words on a registered output with a valid/ready handshake. Runs continuously frame after frame, with no re-initialisation between words. Reports overrun and busy status. Sits between the SPI pin-sampling logic and the receive FIFO/consumer.

Parameters:
WIDTH, 10, data bits per word (2..32)
CNT_W, 6, bit-counter width; must satisfy 2^CNT_W > WIDTH (+1 when parity enabled)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
enable  in  1  sample in on this clock; low = pause (state held)
in  in  1  serial data bit
clear  in  1  synchronous abort of partial word (shift reg and counter to 0); completed output word untouched
msb_first  in  1  1 = first bit lands in out[WIDTH-1]; 0 = first bit lands in out[0]; sampled per bit
out  out  WIDTH  last completed word, held until next accepted word
out_valid  out  1  out holds an unconsumed word
out_ready  in  1  consumer accepts out when out_valid & out_ready
finish  out  1  one-cycle pulse on the edge a word completes (accepted or dropped)
busy  out  1  bit counter nonzero (partial word in progress)
overrun  out  1  sticky: a word completed while previous word unconsumed
parity_err  out  1  see Optional Feature; constant 0 when feature compiled out

Behaviour:
- Reset (rst=1 at an edge): shift reg=0, count=0, out=0, out_valid=0, finish=0, busy=0, overrun=0, parity_err=0. Overrides clear, enable and out_ready. Mid-word reset discards the partial word.
- Each edge with enable=1 and clear=0: bit written at position count (msb_first=1: index WIDTH-1-count; 0: index count); count+1.
- Word completes on the edge sampling bit WIDTH-1. The full word, including that final bit, is loaded to out on that same edge. count wraps to 0; finish=1 for that cycle only. No idle gap: the next enabled edge is bit 0 of the next word.
- Handshake: out_valid clears on an edge with out_valid & out_ready, unless a new word completes on that same edge. In that case the new word loads, out_valid stays 1 and there is no overrun.
- Overrun: word completes while out_valid=1 and out_ready=0. The new word is dropped, out is unchanged, overrun is set and holds until rst.
- enable=0: count, shift reg and outputs hold; the handshake still operates.
- clear=1: count=0 and shift reg=0 on the next edge; the bit on in is ignored. clear has priority over enable.
- clear and word completion on the same edge: clear wins and no word is produced.
- busy = (count != 0), registered with count.
- msb_first changing mid-word is legal; each bit is placed per the current value.

Optional Feature:
Macro STOP_DESER_PARITY_EN.
- Defined: each frame is WIDTH data bits followed by one even-parity bit, for WIDTH+1 enabled edges per frame.
  - Word loads to out, and finish pulses, on the parity-bit edge.
  - parity_err is registered and updates on every completed frame (accepted or dropped): 1 if XOR(data bits, parity bit) = 1, else 0. Holds until the next completed frame; cleared by rst.
- Undefined: frame is WIDTH bits and parity_err is tied 0.

Test Plan:
1. WIDTH=8, msb_first=1, enable=1, bits 1,0,1,1,0,0,0,1, out_ready=0 -> after 8th edge: out=0xB1, out_valid=1, finish high exactly one cycle, busy=0.
2. WIDTH=8, msb_first=0, same bit sequence -> out=0x8D. Then out_ready=1 for one cycle -> out_valid=0 and out stays 0x8D.
3. Back-to-back: word 0xB1, then 8 more bits forming 0x0F with out_ready held 0 -> overrun=1, out stays 0xB1. Next rst -> overrun=0, out=0.
4. Simultaneous: out_valid=1 and out_ready=1 on the edge the second word 0x0F completes -> out=0x0F, out_valid=1, overrun=0.
5. Pause/abort: 3 bits sent, enable=0 for 5 cycles -> busy stays 1 and count holds; resume for 5 bits -> correct word. Separately: 4 bits sent, then clear=1 -> busy=0; a fresh 8 bits give the correct word.
6. STOP_DESER_PARITY_EN defined, WIDTH=8, data 0xB1 (four 1s), parity bit 0 -> parity_err=0. Same data with parity bit 1 -> parity_err=1, out=0xB1, out_valid=1.
